// File: rtl/tl_sensor_model_if.sv
// Intersection model bus: light codes and car arrivals in, sensors,
// queue occupancy, departure pulses and error flags out.
interface tl_sensor_model_if;
    logic [1:0] La;
    logic [1:0] Lb;
    logic [3:0] arr;
    logic       Ta;
    logic       Tal;
    logic       Tb;
    logic       Tbl;
    logic [3:0] q_a;
    logic [3:0] q_al;
    logic [3:0] q_b;
    logic [3:0] q_bl;
    logic [3:0] depart;
    logic [2:0] err;

    modport master (
        output La, Lb, arr,
        input  Ta, Tal, Tb, Tbl, q_a, q_al, q_b, q_bl, depart, err
    );

    modport slave (
        input  La, Lb, arr,
        output Ta, Tal, Tb, Tbl, q_a, q_al, q_b, q_bl, depart, err
    );
endinterface

// File: rtl/tl_sensor_model.sv
// Intersection model driven by a traffic-light controller: per-lane car
// queues with gap-limited departures, sensor outputs and sticky error flags.

module tl_lane_q #(
    parameter int QMAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serve,
    input  logic       gap_zero,
    input  logic       arr,
    output logic       dep,
    output logic       ovf,
    output logic [3:0] q
);
    localparam logic [3:0] QTOP = 4'(QMAX);

    assign dep = serve && gap_zero && (q != 4'd0);
    assign ovf = arr && !dep && (q == QTOP);

    // Arrival and departure on the same edge cancel out.
    always_ff @(posedge clk) begin
        if (reset)
            q <= 4'd0;
        else if (arr && !dep && (q != QTOP))
            q <= q + 4'd1;
        else if (dep && !arr)
            q <= q - 4'd1;
    end
endmodule

module tl_sensor_model #(
    parameter int DEPART_GAP = 2,
    parameter int QMAX       = 15
) (
    input  logic              clk,
    input  logic              reset,
    tl_sensor_model_if.slave  bus
);
    localparam int NUM_LANES   = 4;
    localparam int NUM_STREETS = 2;
    localparam logic [2:0] GAP_LOAD = 3'(DEPART_GAP - 1);

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        LEFT   = 2'b10,
        RED    = 2'b11
    } light_t;

    logic [NUM_LANES-1:0]        serve;
    logic [NUM_LANES-1:0]        dep;
    logic [NUM_LANES-1:0]        ovf;
    logic [NUM_LANES-1:0][3:0]   q;
    logic [NUM_STREETS-1:0]      srv_st;
    logic [NUM_STREETS-1:0][2:0] gap;
    logic [NUM_LANES-1:0]        depart_q;
    logic [2:0]                  err_q;
    logic [1:0]                  la_prev;
    logic [1:0]                  lb_prev;
    logic                        prev_valid;

    function automatic logic legal_step(input logic [1:0] p, input logic [1:0] c);
        logic ok;
        ok = 1'b0;
        if (p == c) ok = 1'b1;
        else begin
            case (p)
                GREEN:   ok = (c == YELLOW);
                YELLOW:  ok = (c == LEFT) || (c == RED);
                LEFT:    ok = (c == YELLOW);
                RED:     ok = (c == GREEN);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    assign serve[0] = (bus.La == GREEN);
    assign serve[1] = (bus.La == LEFT);
    assign serve[2] = (bus.Lb == GREEN);
    assign serve[3] = (bus.Lb == LEFT);

    genvar s, l;
    generate
        for (s = 0; s < NUM_STREETS; s++) begin : g_street
            assign srv_st[s] = serve[2*s] | serve[2*s+1];

            // Gap counter only runs while the street is serving some lane.
            always_ff @(posedge clk) begin
                if (reset || !srv_st[s])
                    gap[s] <= 3'd0;
                else if (gap[s] != 3'd0)
                    gap[s] <= gap[s] - 3'd1;
                else if (|dep[2*s+1 -: 2])
                    gap[s] <= GAP_LOAD;
                else
                    gap[s] <= 3'd0;
            end
        end

        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            tl_lane_q #(.QMAX(QMAX)) u_lane (
                .clk      (clk),
                .reset    (reset),
                .serve    (serve[l]),
                .gap_zero (gap[l/2] == 3'd0),
                .arr      (bus.arr[l]),
                .dep      (dep[l]),
                .ovf      (ovf[l]),
                .q        (q[l])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            depart_q   <= '0;
            err_q      <= '0;
            la_prev    <= RED;
            lb_prev    <= RED;
            prev_valid <= 1'b0;
        end else begin
            depart_q   <= dep;
            la_prev    <= bus.La;
            lb_prev    <= bus.Lb;
            prev_valid <= 1'b1;
            if ((bus.La != RED) && (bus.Lb != RED))
                err_q[0] <= 1'b1;
            if (prev_valid && (!legal_step(la_prev, bus.La) || !legal_step(lb_prev, bus.Lb)))
                err_q[1] <= 1'b1;
            if (|ovf)
                err_q[2] <= 1'b1;
        end
    end

    assign bus.q_a    = q[0];
    assign bus.q_al   = q[1];
    assign bus.q_b    = q[2];
    assign bus.q_bl   = q[3];
    assign bus.Ta     = (q[0] != 4'd0);
    assign bus.Tal    = (q[1] != 4'd0);
    assign bus.Tb     = (q[2] != 4'd0);
    assign bus.Tbl    = (q[3] != 4'd0);
    assign bus.depart = depart_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_tl_sensor_model.sv
// Directed bench for tl_sensor_model: fill, gap-limited drain, simultaneous
// arrival/departure, overflow, protocol errors and mid-drain reset.
module tb_tl_sensor_model;
    logic clk = 1'b0;
    logic reset;

    tl_sensor_model_if bus();

    tl_sensor_model #(.DEPART_GAP(2), .QMAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] G = 2'b00, Y = 2'b01, L = 2'b10, R = 2'b11;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    logic [3:0] exp_dep [6] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    logic [3:0] exp_qa  [6] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};

    initial begin
        reset   = 1'b1;
        bus.La  = R;
        bus.Lb  = R;
        bus.arr = 4'b0000;
        tick(2);
        chk("rst_qa", bus.q_a, 4'd0);
        chk("rst_qal", bus.q_al, 4'd0);
        chk("rst_qb", bus.q_b, 4'd0);
        chk("rst_qbl", bus.q_bl, 4'd0);
        chk("rst_T", {bus.Ta, bus.Tal, bus.Tb, bus.Tbl}, 4'b0000);
        chk("rst_dep", bus.depart, 4'b0000);
        chk("rst_err", bus.err, 3'b000);
        reset = 1'b0;

        // Fill A straight while both streets are red.
        bus.arr = 4'b0001;
        tick(3);
        bus.arr = 4'b0000;
        chk("fill_qa", bus.q_a, 4'd3);
        chk("fill_Ta", bus.Ta, 1'b1);
        chk("fill_dep", bus.depart, 4'b0000);
        chk("fill_err", bus.err, 3'b000);

        // Drain with DEPART_GAP=2: pulses on cycles 1, 3, 5.
        bus.La = G;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk($sformatf("drain_dep%0d", i), bus.depart, exp_dep[i]);
            chk($sformatf("drain_qa%0d", i), bus.q_a, exp_qa[i]);
        end
        chk("drain_Ta", bus.Ta, 1'b0);
        chk("drain_err", bus.err, 3'b000);

        // Simultaneous arrival and departure on A left.
        bus.La = Y;
        bus.Lb = R;
        do_reset();
        bus.arr = 4'b0010;
        tick(2);
        bus.arr = 4'b0000;
        chk("sim_fill_qal", bus.q_al, 4'd2);
        chk("sim_fill_Tal", bus.Tal, 1'b1);
        bus.La  = L;
        bus.arr = 4'b0010;
        tick(1);
        bus.arr = 4'b0000;
        chk("sim_qal", bus.q_al, 4'd2);
        chk("sim_dep", bus.depart, 4'b0010);
        tick(1);
        chk("sim_gap_qal", bus.q_al, 4'd2);
        chk("sim_gap_dep", bus.depart, 4'b0000);
        chk("sim_err", bus.err, 3'b000);

        // Overflow on B straight.
        bus.La = R;
        bus.Lb = R;
        do_reset();
        bus.arr = 4'b0100;
        tick(15);
        chk("ovf_full_qb", bus.q_b, 4'd15);
        chk("ovf_full_err", bus.err, 3'b000);
        chk("ovf_Tb", bus.Tb, 1'b1);
        tick(1);
        bus.arr = 4'b0000;
        chk("ovf_qb", bus.q_b, 4'd15);
        chk("ovf_err", bus.err, 3'b100);

        // Protocol errors and their persistence.
        bus.La = G;
        bus.Lb = R;
        do_reset();
        tick(1);
        chk("prot_first_err", bus.err, 3'b000);
        bus.La = L;
        tick(1);
        chk("prot_illegal", bus.err, 3'b010);
        bus.La = G;
        bus.Lb = Y;
        tick(1);
        chk("prot_conflict", bus.err, 3'b011);
        bus.La = R;
        bus.Lb = R;
        tick(3);
        chk("prot_sticky", bus.err, 3'b011);
        do_reset();
        chk("prot_cleared", bus.err, 3'b000);

        // Reset mid-drain discards queue and in-flight state.
        bus.arr = 4'b0001;
        tick(5);
        bus.arr = 4'b0000;
        chk("mid_fill_qa", bus.q_a, 4'd5);
        bus.La = G;
        tick(1);
        chk("mid_drain_qa", bus.q_a, 4'd4);
        chk("mid_drain_dep", bus.depart, 4'b0001);
        reset   = 1'b1;
        bus.arr = 4'b0001;
        tick(1);
        reset   = 1'b0;
        bus.arr = 4'b0000;
        chk("mid_rst_qa", bus.q_a, 4'd0);
        chk("mid_rst_dep", bus.depart, 4'b0000);
        chk("mid_rst_err", bus.err, 3'b000);
        chk("mid_rst_Ta", bus.Ta, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
